// File: rtl/ddr5_mc_pwr_sequencer.sv
// DDR5 per-platform power sequencer: brings memory controllers up one at a
// time (DRAMPWROK enable, wait for DDRIO VR good, stagger), then releases all
// DIMM resets together. Power-down holds DIMM reset before dropping DRAMPWROK.
// DDRIO timeouts and runtime power-good loss are flagged per MC.
//
// Ports:
//   iClk, iRst              clock, async active-high reset
//   iPwrEn                  power-up request (low = power-down)
//   iDimmPwrOK              DIMM main rail good
//   iMcEn                   MC populated mask (latched at sequence start)
//   iPWRGD_DRAMPWRGD_DDRIO  per-MC DDRIO VR power-good
//   oDramPwrOkEn            per-MC DRAMPWROK enable
//   oDimmRstRel             per-MC DIMM reset release (1 = out of reset)
//   oBusy / oDone / oFault  sequencing / all up / fault status
//   oFaultMc                sticky per-MC fault flags
module ddr5_mc_pwr_sequencer #(
    parameter int MC_SIZE      = 4,
    parameter int STAGGER_DLY  = 4,
    parameter int RST_HOLD_DLY = 600,
    parameter int TIMEOUT      = 1000,
    parameter int CNT_W        = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iPwrEn,
    input  logic               iDimmPwrOK,
    input  logic [MC_SIZE-1:0] iMcEn,
    input  logic [MC_SIZE-1:0] iPWRGD_DRAMPWRGD_DDRIO,
    output logic [MC_SIZE-1:0] oDramPwrOkEn,
    output logic [MC_SIZE-1:0] oDimmRstRel,
    output logic               oBusy,
    output logic               oDone,
    output logic               oFault,
    output logic [MC_SIZE-1:0] oFaultMc
);

    localparam int IW = $clog2(MC_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE, SEL, WAIT_IO, STAG, ON, PD_RST, PD_OFF, FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [MC_SIZE-1:0] mask_q, mask_d;
    logic [MC_SIZE-1:0] pwrok_q, pwrok_d;
    logic [MC_SIZE-1:0] rstrel_q, rstrel_d;
    logic [MC_SIZE-1:0] fmc_q, fmc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;

    logic [MC_SIZE-1:0] sel;
    logic [MC_SIZE-1:0] lost;
    logic [CNT_W-1:0]   timer_inc;
    logic               abort;

    // One-hot of the MC being sequenced; all zero once idx reaches MC_SIZE,
    // which keeps every per-MC lookup in range.
    always_comb begin
        sel = '0;
        for (int i = 0; i < MC_SIZE; i++) begin
            sel[i] = (idx_q == IW'(i));
        end
    end

    assign abort     = !iPwrEn || !iDimmPwrOK;
    assign lost      = mask_q & ~iPWRGD_DRAMPWRGD_DDRIO;
    // Saturating increment: the timer never wraps.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        mask_d   = mask_q;
        pwrok_d  = pwrok_q;
        rstrel_d = rstrel_q;
        fmc_d    = fmc_q;
        done_d   = done_q;
        fault_d  = fault_q;

        unique case (state_q)
            IDLE: begin
                if (iPwrEn && iDimmPwrOK) begin
                    mask_d  = iMcEn;
                    fmc_d   = '0;
                    idx_d   = '0;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (abort) begin
                    state_d = PD_RST;
                end else if (idx_q == IW'(MC_SIZE)) begin
                    rstrel_d = mask_q;
                    done_d   = 1'b1;
                    state_d  = ON;
                end else if ((mask_q & sel) == '0) begin
                    idx_d = idx_q + IW'(1);
                end else begin
                    pwrok_d = pwrok_q | sel;
                    timer_d = '0;
                    state_d = WAIT_IO;
                end
            end
            WAIT_IO: begin
                // Abort beats a same-cycle good; a good beats the timeout.
                if (abort) begin
                    state_d = PD_RST;
                end else if ((iPWRGD_DRAMPWRGD_DDRIO & sel) != '0) begin
                    timer_d = '0;
                    state_d = STAG;
                end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
                    fmc_d   = fmc_q | sel;
                    state_d = FAULT;
                end else begin
                    timer_d = timer_inc;
                end
            end
            STAG: begin
                if (abort) begin
                    state_d = PD_RST;
                end else if (timer_q >= CNT_W'(STAGGER_DLY - 1)) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = SEL;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ON: begin
                if (lost != '0) begin
                    fmc_d   = fmc_q | lost;
                    state_d = FAULT;
                end else if (abort) begin
                    state_d = PD_RST;
                end
            end
            PD_RST: begin
                if (timer_q >= CNT_W'(RST_HOLD_DLY - 1)) begin
                    state_d = PD_OFF;
                end else begin
                    timer_d = timer_inc;
                end
            end
            PD_OFF: begin
                pwrok_d = '0;
                state_d = IDLE;
            end
            FAULT: begin
                if (!iPwrEn) begin
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entry actions shared by every path into these states.
        if (state_d == PD_RST && state_q != PD_RST) begin
            rstrel_d = '0;
            done_d   = 1'b0;
            timer_d  = '0;
        end
        if (state_d == FAULT && state_q != FAULT) begin
            pwrok_d  = '0;
            rstrel_d = '0;
            done_d   = 1'b0;
            fault_d  = 1'b1;
        end

        busy_d = !(state_d inside {IDLE, ON, FAULT});
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            mask_q   <= '0;
            pwrok_q  <= '0;
            rstrel_q <= '0;
            fmc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            mask_q   <= mask_d;
            pwrok_q  <= pwrok_d;
            rstrel_q <= rstrel_d;
            fmc_q    <= fmc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign oDramPwrOkEn = pwrok_q;
    assign oDimmRstRel  = rstrel_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oFault       = fault_q;
    assign oFaultMc     = fmc_q;

endmodule

// File: tb/tb_ddr5_mc_pwr_sequencer.sv
// Bench for ddr5_mc_pwr_sequencer: directed stimulus pushes expected output
// snapshots tagged with an edge number; a monitor pops and compares them.
module tb_ddr5_mc_pwr_sequencer;

    logic       clk = 1'b0;
    logic       iRst;
    logic       iPwrEn;
    logic       iDimmPwrOK;
    logic [3:0] iMcEn;
    logic [3:0] iDdrio;
    logic [3:0] oDramPwrOkEn;
    logic [3:0] oDimmRstRel;
    logic       oBusy;
    logic       oDone;
    logic       oFault;
    logic [3:0] oFaultMc;

    ddr5_mc_pwr_sequencer #(
        .MC_SIZE(4),
        .STAGGER_DLY(4),
        .RST_HOLD_DLY(8),
        .TIMEOUT(20),
        .CNT_W(16)
    ) dut (
        .iClk(clk),
        .iRst(iRst),
        .iPwrEn(iPwrEn),
        .iDimmPwrOK(iDimmPwrOK),
        .iMcEn(iMcEn),
        .iPWRGD_DRAMPWRGD_DDRIO(iDdrio),
        .oDramPwrOkEn(oDramPwrOkEn),
        .oDimmRstRel(oDimmRstRel),
        .oBusy(oBusy),
        .oDone(oDone),
        .oFault(oFault),
        .oFaultMc(oFaultMc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      nm;
        logic [3:0] pw;
        logic [3:0] rr;
        logic       bz;
        logic       dn;
        logic       ft;
        logic [3:0] fm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   ecnt  = 0;
    int   b     = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(string nm, string f, logic [3:0] act, logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %b want %b (edge %0d)",
                     nm, f, act, req, ecnt);
        end
    endtask

    task automatic ex(int k, string nm, logic [3:0] pw, logic [3:0] rr,
                      logic bz, logic dn, logic ft, logic [3:0] fm);
        exp_t x;
        x.cyc = b + k;
        x.nm  = nm;
        x.pw  = pw;
        x.rr  = rr;
        x.bz  = bz;
        x.dn  = dn;
        x.ft  = ft;
        x.fm  = fm;
        q.push_back(x);
    endtask

    task automatic at(int tgt);
        while (ecnt < tgt) @(negedge clk);
    endtask

    // Monitor: one output snapshot per edge, matched against the queue.
    always @(posedge clk) begin
        ecnt++;
        #1;
        while (q.size() > 0 && q[0].cyc <= ecnt) begin
            e = q.pop_front();
            if (e.cyc < ecnt) begin
                total++;
                bad++;
                $display("FAIL %s: missed edge %0d (now %0d)",
                         e.nm, e.cyc, ecnt);
            end else begin
                chk(e.nm, "pwrok",  oDramPwrOkEn, e.pw);
                chk(e.nm, "rstrel", oDimmRstRel,  e.rr);
                chk(e.nm, "busy",   {3'b0, oBusy},  {3'b0, e.bz});
                chk(e.nm, "done",   {3'b0, oDone},  {3'b0, e.dn});
                chk(e.nm, "fault",  {3'b0, oFault}, {3'b0, e.ft});
                chk(e.nm, "faultmc", oFaultMc, e.fm);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iRst       = 1'b1;
        iPwrEn     = 1'b0;
        iDimmPwrOK = 1'b0;
        iMcEn      = 4'h0;
        iDdrio     = 4'h0;

        @(negedge clk);
        b = ecnt;
        ex(1, "reset", 4'h0, 4'h0, 0, 0, 0, 4'h0);
        at(b + 2);
        iRst = 1'b0;

        // Full power-up, DDRIO good 3 cycles after each enable.
        at(b + 3);
        b = ecnt;
        iPwrEn     = 1'b1;
        iDimmPwrOK = 1'b1;
        iMcEn      = 4'hF;
        ex(1,  "t1_start", 4'h0, 4'h0, 1, 0, 0, 4'h0);
        ex(2,  "t1_en0",   4'h1, 4'h0, 1, 0, 0, 4'h0);
        ex(9,  "t1_stag0", 4'h1, 4'h0, 1, 0, 0, 4'h0);
        ex(10, "t1_en1",   4'h3, 4'h0, 1, 0, 0, 4'h0);
        ex(18, "t1_en2",   4'h7, 4'h0, 1, 0, 0, 4'h0);
        ex(26, "t1_en3",   4'hF, 4'h0, 1, 0, 0, 4'h0);
        ex(33, "t1_last",  4'hF, 4'h0, 1, 0, 0, 4'h0);
        ex(34, "t1_on",    4'hF, 4'hF, 0, 1, 0, 4'h0);
        for (int n = 0; n < 4; n++) begin
            at(b + 4 + 8 * n);
            iDdrio[n] = 1'b1;
        end

        // Power-down from ON; re-request during the hold is ignored.
        at(b + 36);
        b = ecnt;
        iPwrEn = 1'b0;
        ex(1,  "t4_rst",  4'hF, 4'h0, 1, 0, 0, 4'h0);
        ex(9,  "t4_hold", 4'hF, 4'h0, 1, 0, 0, 4'h0);
        ex(10, "t4_off",  4'h0, 4'h0, 0, 0, 0, 4'h0);
        ex(11, "t4_idle", 4'h0, 4'h0, 0, 0, 0, 4'h0);
        at(b + 2);
        iPwrEn = 1'b1;
        at(b + 10);
        iPwrEn = 1'b0;
        at(b + 11);
        iDdrio = 4'h0;

        // Masked MCs, mask change after start, then runtime loss of MC1.
        at(b + 12);
        b = ecnt;
        iPwrEn = 1'b1;
        iMcEn  = 4'b1010;
        ex(1,  "t2_start", 4'h0, 4'h0, 1, 0, 0, 4'h0);
        ex(2,  "t2_skip0", 4'h0, 4'h0, 1, 0, 0, 4'h0);
        ex(3,  "t2_en1",   4'h2, 4'h0, 1, 0, 0, 4'h0);
        ex(11, "t2_skip2", 4'h2, 4'h0, 1, 0, 0, 4'h0);
        ex(12, "t2_en3",   4'hA, 4'h0, 1, 0, 0, 4'h0);
        ex(19, "t2_last",  4'hA, 4'h0, 1, 0, 0, 4'h0);
        ex(20, "t2_on",    4'hA, 4'hA, 0, 1, 0, 4'h0);
        ex(23, "t5_loss",  4'h0, 4'h0, 0, 0, 1, 4'h2);
        ex(26, "t5_hold",  4'h0, 4'h0, 0, 0, 1, 4'h2);
        ex(28, "t5_clr",   4'h0, 4'h0, 0, 0, 0, 4'h2);
        at(b + 1);
        iMcEn = 4'hF;
        at(b + 5);
        iDdrio[1] = 1'b1;
        at(b + 14);
        iDdrio[3] = 1'b1;
        at(b + 22);
        iDdrio[1] = 1'b0;
        at(b + 27);
        iPwrEn = 1'b0;
        at(b + 28);
        iDdrio = 4'h0;

        // MC2 DDRIO never rises: timeout 20 cycles after its enable.
        at(b + 29);
        b = ecnt;
        iPwrEn = 1'b1;
        iMcEn  = 4'hF;
        ex(1,  "t3_start", 4'h0, 4'h0, 1, 0, 0, 4'h0);
        ex(18, "t3_en2",   4'h7, 4'h0, 1, 0, 0, 4'h0);
        ex(37, "t3_wait",  4'h7, 4'h0, 1, 0, 0, 4'h0);
        ex(38, "t3_tmo",   4'h0, 4'h0, 0, 0, 1, 4'h4);
        ex(41, "t3_hold",  4'h0, 4'h0, 0, 0, 1, 4'h4);
        ex(43, "t3_clr",   4'h0, 4'h0, 0, 0, 0, 4'h4);
        at(b + 4);
        iDdrio[0] = 1'b1;
        at(b + 12);
        iDdrio[1] = 1'b1;
        at(b + 42);
        iPwrEn = 1'b0;
        at(b + 43);
        iDdrio = 4'h0;

        // Empty mask: walks SEL once per MC, then ON with no releases.
        at(b + 44);
        b = ecnt;
        iPwrEn = 1'b1;
        iMcEn  = 4'h0;
        ex(5,  "z_sel",  4'h0, 4'h0, 1, 0, 0, 4'h0);
        ex(6,  "z_on",   4'h0, 4'h0, 0, 1, 0, 4'h0);
        ex(17, "z_idle", 4'h0, 4'h0, 0, 0, 0, 4'h0);
        at(b + 7);
        iPwrEn = 1'b0;

        // DIMM power loss while staggering after MC1.
        at(b + 18);
        b = ecnt;
        iPwrEn = 1'b1;
        iMcEn  = 4'hF;
        ex(10, "t6_en1",   4'h3, 4'h0, 1, 0, 0, 4'h0);
        ex(15, "t6_abort", 4'h3, 4'h0, 1, 0, 0, 4'h0);
        ex(23, "t6_hold",  4'h3, 4'h0, 1, 0, 0, 4'h0);
        ex(24, "t6_off",   4'h0, 4'h0, 0, 0, 0, 4'h0);
        at(b + 4);
        iDdrio[0] = 1'b1;
        at(b + 12);
        iDdrio[1] = 1'b1;
        at(b + 14);
        iDimmPwrOK = 1'b0;
        at(b + 15);
        iPwrEn = 1'b0;
        iDdrio = 4'h0;
        at(b + 25);
        iDimmPwrOK = 1'b1;

        // Async reset in WAIT_IO clears outputs without a clock edge.
        at(b + 26);
        b = ecnt;
        iPwrEn = 1'b1;
        iMcEn  = 4'hF;
        ex(2, "t7_en0", 4'h1, 4'h0, 1, 0, 0, 4'h0);
        at(b + 4);
        #2;
        iRst = 1'b1;
        #1;
        chk("t7_async", "pwrok",  oDramPwrOkEn, 4'h0);
        chk("t7_async", "busy",   {3'b0, oBusy}, 4'h0);
        chk("t7_async", "faultmc", oFaultMc, 4'h0);
        iPwrEn = 1'b0;
        at(b + 6);
        b = ecnt;
        ex(1, "t7_held", 4'h0, 4'h0, 0, 0, 0, 4'h0);
        at(b + 2);
        iRst = 1'b0;
        b = ecnt;
        ex(2, "t7_after", 4'h0, 4'h0, 0, 0, 0, 4'h0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total += q.size();
            bad   += q.size();
            $display("FAIL drain: %0d expectations unchecked, want 0",
                     q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
